// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one outstanding access, fixed-latency memory,
// byte/half/word alignment checks, store lane steering and load extension.
module lsu_ctrl #(
    parameter int unsigned LATENCY    = 1,
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_wen,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic             wen_q;
    logic [1:0]       size_q;
    logic             signed_q;

    logic        accept;
    logic        illegal;
    logic        last_wait;
    logic [4:0]  shamt;
    logic [31:0] rd_shifted;
    logic [31:0] load_ext;

    assign req_ready  = (state == S_IDLE);
    assign resp_valid = (state == S_RESP);
    assign accept     = req_valid && req_ready;
    assign last_wait  = (state == S_WAIT) && (cnt == '0);

    // Alignment / size legality of the incoming request
    always_comb begin
        illegal = 1'b0;
        case (req_size)
            SZ_HALF: illegal = req_addr[0];
            SZ_WORD: illegal = (req_addr[1:0] != 2'b00);
            SZ_ILL:  illegal = 1'b1;
            default: illegal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = illegal ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Request capture, wait counter and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            addr_q     <= RESET_ADDR;
            wdata_q    <= '0;
            wen_q      <= 1'b0;
            size_q     <= SZ_ILL;
            signed_q   <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            cnt        <= CNT_W'(LATENCY - 1);
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            wen_q      <= req_wen;
            size_q     <= req_size;
            signed_q   <= req_signed;
            resp_rdata <= '0;
            resp_err   <= illegal;
        end else if (state == S_WAIT) begin
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else if (!wen_q) begin
                resp_rdata <= load_ext;
            end
        end
    end

    assign shamt      = {addr_q[1:0], 3'b000};
    assign rd_shifted = mem_rdata >> shamt;

    always_comb begin
        load_ext = rd_shifted;
        case (size_q)
            SZ_BYTE: load_ext = signed_q ? {{24{rd_shifted[7]}}, rd_shifted[7:0]}
                                         : {24'h0, rd_shifted[7:0]};
            SZ_HALF: load_ext = signed_q ? {{16{rd_shifted[15]}}, rd_shifted[15:0]}
                                         : {16'h0, rd_shifted[15:0]};
            default: load_ext = rd_shifted;
        endcase
    end

    // Size code 3 (also the reset value) yields an all-zero mask
    always_comb begin
        mem_wmask = 4'b0000;
        case (size_q)
            SZ_BYTE: mem_wmask = 4'b0001 << addr_q[1:0];
            SZ_HALF: mem_wmask = 4'b0011 << addr_q[1:0];
            SZ_WORD: mem_wmask = 4'b1111;
            default: mem_wmask = 4'b0000;
        endcase
    end

    assign mem_raddr = {addr_q[31:2], 2'b00};
    assign mem_waddr = {addr_q[31:2], 2'b00};
    assign mem_wdata = wdata_q << shamt;
    assign mem_wen   = last_wait && wen_q && !rst;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: LATENCY=1 and LATENCY=3 instances checked
// against hand-computed cycle-by-cycle expectations.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] mem_rdata;

    logic        req_valid1, resp_ready1;
    logic        req_ready1, resp_valid1, resp_err1, mem_wen1;
    logic [31:0] resp_rdata1, mem_raddr1, mem_waddr1, mem_wdata1;
    logic [3:0]  mem_wmask1;

    logic        req_valid3, resp_ready3;
    logic        req_ready3, resp_valid3, resp_err3, mem_wen3;
    logic [31:0] resp_rdata3, mem_raddr3, mem_waddr3, mem_wdata3;
    logic [3:0]  mem_wmask3;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.LATENCY(1), .RESET_ADDR(32'h8000_0000)) u_lat1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1),
        .mem_raddr(mem_raddr1), .mem_rdata(mem_rdata), .mem_wen(mem_wen1),
        .mem_waddr(mem_waddr1), .mem_wdata(mem_wdata1), .mem_wmask(mem_wmask1)
    );

    lsu_ctrl #(.LATENCY(3), .RESET_ADDR(32'h8000_0000)) u_lat3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_signed(req_signed),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3),
        .mem_raddr(mem_raddr3), .mem_rdata(mem_rdata), .mem_wen(mem_wen3),
        .mem_waddr(mem_waddr3), .mem_wdata(mem_wdata3), .mem_wmask(mem_wmask3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [1:0] size, input logic sgn);
        req_wen    = wen;
        req_addr   = addr;
        req_wdata  = wdata;
        req_size   = size;
        req_signed = sgn;
    endtask

    // LATENCY=1 load: accept, one WAIT cycle, check response two cycles later
    task automatic load1(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [31:0] rdata, input logic [31:0] exp);
        set_req(1'b0, addr, 32'h0, size, sgn);
        mem_rdata  = rdata;
        req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        check({tag, "_wait_nowen"}, 32'(mem_wen1), 32'h0);
        tick();
        check({tag, "_valid"}, 32'(resp_valid1), 32'h1);
        check({tag, "_err"}, 32'(resp_err1), 32'h0);
        check({tag, "_rdata"}, resp_rdata1, exp);
        tick();
    endtask

    initial begin
        rst         = 1'b1;
        req_valid1  = 1'b0;
        req_valid3  = 1'b0;
        resp_ready1 = 1'b1;
        resp_ready3 = 1'b1;
        mem_rdata   = 32'h0;
        set_req(1'b0, 32'h0, 32'h0, 2'd0, 1'b0);
        tick();
        tick();
        rst = 1'b0;

        check("rst_ready1", 32'(req_ready1), 32'h1);
        check("rst_valid1", 32'(resp_valid1), 32'h0);
        check("rst_rdata1", resp_rdata1, 32'h0);
        check("rst_err1", 32'(resp_err1), 32'h0);
        check("rst_raddr1", mem_raddr1, 32'h8000_0000);
        check("rst_wmask1", 32'(mem_wmask1), 32'h0);
        check("rst_wen1", 32'(mem_wen1), 32'h0);
        check("rst_raddr3", mem_raddr3, 32'h8000_0000);

        // sw 0xDEADBEEF -> 0x8000_0004
        set_req(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0);
        req_valid1 = 1'b1;
        check("sw_T_wen", 32'(mem_wen1), 32'h0);
        tick();
        req_valid1 = 1'b0;
        check("sw_T1_wen", 32'(mem_wen1), 32'h1);
        check("sw_T1_wmask", 32'(mem_wmask1), 32'hF);
        check("sw_T1_waddr", mem_waddr1, 32'h8000_0004);
        check("sw_T1_wdata", mem_wdata1, 32'hDEAD_BEEF);
        check("sw_T1_valid", 32'(resp_valid1), 32'h0);
        tick();
        check("sw_T2_valid", 32'(resp_valid1), 32'h1);
        check("sw_T2_err", 32'(resp_err1), 32'h0);
        check("sw_T2_wen", 32'(mem_wen1), 32'h0);
        check("sw_T2_rdata", resp_rdata1, 32'h0);
        tick();
        check("sw_T3_ready", 32'(req_ready1), 32'h1);

        load1("lb_s", 32'h8000_0003, 2'd0, 1'b1, 32'h80FF_0000, 32'hFFFF_FF80);
        load1("lb_u", 32'h8000_0003, 2'd0, 1'b0, 32'h80FF_0000, 32'h0000_0080);
        load1("lh_s", 32'h8000_0002, 2'd1, 1'b1, 32'h80FF_0000, 32'hFFFF_80FF);
        load1("lhu1", 32'h8000_0000, 2'd1, 1'b0, 32'h1234_F00D, 32'h0000_F00D);
        load1("lw", 32'h8000_0008, 2'd2, 1'b1, 32'h8765_4321, 32'h8765_4321);

        // sh 0x1234 -> 0x8000_0002
        set_req(1'b1, 32'h8000_0002, 32'h0000_1234, 2'd1, 1'b0);
        req_valid1 = 1'b1;
        tick();
        req_valid1 = 1'b0;
        check("sh_wen", 32'(mem_wen1), 32'h1);
        check("sh_wmask", 32'(mem_wmask1), 32'hC);
        check("sh_wdata", mem_wdata1, 32'h1234_0000);
        check("sh_waddr", mem_waddr1, 32'h8000_0000);
        tick();
        tick();

        // lw at 0x8000_0001: misaligned, straight to RESP
        set_req(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0);
        mem_rdata   = 32'hFFFF_FFFF;
        resp_ready1 = 1'b0;
        req_valid1  = 1'b1;
        tick();
        check("mis_valid", 32'(resp_valid1), 32'h1);
        check("mis_err", 32'(resp_err1), 32'h1);
        check("mis_rdata", resp_rdata1, 32'h0);
        check("mis_wen", 32'(mem_wen1), 32'h0);
        // request presented during RESP must not be captured
        set_req(1'b1, 32'h1111_2220, 32'h0, 2'd2, 1'b0);
        tick();
        check("ign_raddr", mem_raddr1, 32'h8000_0000);
        check("ign_wen", 32'(mem_wen1), 32'h0);
        check("ign_valid", 32'(resp_valid1), 32'h1);
        req_valid1  = 1'b0;
        resp_ready1 = 1'b1;
        tick();
        check("mis_ready", 32'(req_ready1), 32'h1);
        check("mis_after_wen", 32'(mem_wen1), 32'h0);

        // LATENCY=3 load with delayed resp_ready
        set_req(1'b0, 32'h8000_0008, 32'h0, 2'd2, 1'b0);
        mem_rdata   = 32'hCAFE_F00D;
        resp_ready3 = 1'b0;
        req_valid3  = 1'b1;
        tick();
        req_valid3 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check($sformatf("l3_wait%0d_valid", i), 32'(resp_valid3), 32'h0);
            check($sformatf("l3_wait%0d_ready", i), 32'(req_ready3), 32'h0);
            tick();
        end
        mem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("l3_hold%0d_valid", i), 32'(resp_valid3), 32'h1);
            check($sformatf("l3_hold%0d_rdata", i), resp_rdata3, 32'hCAFE_F00D);
            check($sformatf("l3_hold%0d_err", i), 32'(resp_err3), 32'h0);
            tick();
        end
        resp_ready3 = 1'b1;
        check("l3_hs_valid", 32'(resp_valid3), 32'h1);
        tick();
        check("l3_after_ready", 32'(req_ready3), 32'h1);
        check("l3_after_valid", 32'(resp_valid3), 32'h0);

        // LATENCY=3 store, reset on its last WAIT cycle
        set_req(1'b1, 32'h8000_0010, 32'hA5A5_A5A5, 2'd2, 1'b0);
        req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        check("rs_w1_wen", 32'(mem_wen3), 32'h0);
        tick();
        check("rs_w2_wen", 32'(mem_wen3), 32'h0);
        tick();
        rst = 1'b1;
        #1;
        check("rs_last_wen", 32'(mem_wen3), 32'h0);
        tick();
        rst = 1'b0;
        check("rs_ready", 32'(req_ready3), 32'h1);
        check("rs_raddr", mem_raddr3, 32'h8000_0000);
        check("rs_wmask", 32'(mem_wmask3), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rs_noresp%0d", i), 32'(resp_valid3), 32'h0);
            check($sformatf("rs_nowen%0d", i), 32'(mem_wen3), 32'h0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 1, number of WAIT cycles per access (legal range 1..15).
REQ-002 SHALL have parameter RESET_ADDR, default 32'h8000_0000, value held on mem_raddr from reset until the first accepted request.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  core presents a request.
REQ-006 SHALL have port req_ready  output  1  block accepts a request; high only in IDLE.
REQ-007 SHALL have port req_wen  input  1  1=store, 0=load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_size  input  2  access size: 0=byte, 1=half, 2=word, 3=illegal.
REQ-011 SHALL have port req_signed  input  1  load sign-extends when 1, zero-extends when 0.
REQ-012 SHALL have port resp_valid  output  1  response available.
REQ-013 SHALL have port resp_ready  input  1  core consumes the response.
REQ-014 SHALL have port resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 SHALL have port resp_err  output  1  misaligned or illegal-size access.
REQ-016 SHALL have ports mem_raddr output 32, mem_rdata input 32, mem_wen output 1, mem_waddr output 32, mem_wdata output 32, mem_wmask output 4. These connect to the simulation memory, which reads combinationally and writes on the clock edge when mem_wen is high.

Function
REQ-017 SHALL implement the states IDLE, WAIT and RESP, with req_ready = (state==IDLE) and resp_valid = (state==RESP).
REQ-018 On req_valid&&req_ready, SHALL capture wen, addr, wdata, size and signed into registers.
  - If the access is legal, SHALL go to WAIT with the wait counter set to LATENCY-1.
  - If the access is illegal, SHALL go directly to RESP with resp_err=1.
REQ-019 SHALL treat an access as illegal when size==3, when size==1 and addr[0]!=0, or when size==2 and addr[1:0]!=0.
REQ-020 In WAIT, SHALL decrement the counter each cycle and move to RESP in the cycle the counter is 0 (the last WAIT cycle).
REQ-021 SHALL drive mem_raddr = mem_waddr = {addr_q[31:2],2'b00} at all times, holding the value between requests.
REQ-022 SHALL assert mem_wen for exactly one cycle per legal store, namely the last WAIT cycle, and never for loads or illegal accesses.
REQ-023 Store data SHALL be shifted: mem_wdata = wdata_q << (8*addr_q[1:0]).
REQ-024 Store mask SHALL be shifted by the byte offset:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
REQ-025 On the last WAIT cycle of a load, SHALL register resp_rdata from mem_rdata as follows:
  - shift mem_rdata right by 8*off;
  - take the low 8/16/32 bits according to size;
  - sign- or zero-extend according to signed_q.
REQ-026 In RESP, SHALL hold resp_rdata and resp_err stable until resp_ready=1, then return to IDLE on the next edge.
REQ-027 SHALL accept a new request no earlier than the cycle after resp_valid&&resp_ready. With LATENCY=1 and resp_ready tied high, the steady-state throughput is one access per 3 cycles.
REQ-028 req_valid while the block is not in IDLE SHALL be ignored, with no capture.

Reset
REQ-029 rst=1 at an edge SHALL force the following:
  - state=IDLE and counter=0;
  - resp_rdata=0 and resp_err=0;
  - addr_q=RESET_ADDR, so mem_raddr=RESET_ADDR and mem_wmask=4'b0000.
REQ-030 mem_wen SHALL be gated by !rst, so that a reset asserted during the last WAIT cycle produces no memory write; any in-flight access is dropped with no response.

Verification
REQ-031 Bench SHALL cover: sw 0xDEADBEEF to 0x8000_0004 with LATENCY=1 -> accept at T, mem_wen=1 only at T+1 with wmask=1111 and waddr=0x8000_0004, resp_valid at T+2 with err=0.
REQ-032 Bench SHALL cover: lb signed at 0x8000_0003 with mem_rdata=0x80FF_0000 -> resp_rdata=0xFFFF_FF80; the same access unsigned -> 0x0000_0080.
REQ-033 Bench SHALL cover: sh 0x1234 to 0x8000_0002 -> wmask=1100, wdata=0x1234_0000.
REQ-034 Bench SHALL cover: lw at 0x8000_0001 -> resp_valid at T+1 with resp_err=1 and rdata=0, and no mem_wen at any time.
REQ-035 Bench SHALL cover: LATENCY=3 with resp_ready held low for 4 cycles -> resp_valid at T+4, response stable for 4 cycles, req_ready high the cycle after the handshake.
REQ-036 Bench SHALL cover: rst asserted on the last WAIT cycle of a store -> no mem_wen, then IDLE with mem_raddr=0x8000_0000.
